// File: rtl/dram_bram_responder.sv
// BRAM-backed responder that mimics the DDR3 controller user interface.
// Same calibration wait, busy windows and read latency as the DRAM path.
module dram_bram_responder #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int MEM_WORDS_LOG2 = 12,
  parameter int INIT_CYCLES    = 64,
  parameter int READ_LATENCY   = 4,
  parameter int WRITE_BUSY     = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_ren,
  input  logic                      i_wen,
  input  logic [APP_ADDR_WIDTH-2:0] i_addr,
  input  logic [APP_DATA_WIDTH-1:0] i_data,
  input  logic [APP_MASK_WIDTH-1:0] i_mask,
  input  logic                      i_busy,
  output logic                      o_init_calib_complete,
  output logic [APP_DATA_WIDTH-1:0] o_data,
  output logic                      o_data_valid,
  output logic                      o_busy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_RWAIT,
    S_RHOLD
  } state_t;

  state_t                    r_state;
  logic [31:0]               r_cnt;
  logic [MEM_WORDS_LOG2-1:0] r_idx;
  logic [APP_DATA_WIDTH-1:0] r_mem [0:(1<<MEM_WORDS_LOG2)-1];

  logic [MEM_WORDS_LOG2-1:0] w_idx;
  logic                      w_wr;
  logic                      w_unused_addr;

  // Addresses count 16-bit units; a beat spans 8 of them.
  assign w_idx = i_addr[MEM_WORDS_LOG2+2:3];
  assign w_wr  = (r_state == S_IDLE) && i_wen;
  assign w_unused_addr = ^{i_addr[APP_ADDR_WIDTH-2:MEM_WORDS_LOG2+3],
                           i_addr[2:0]};

  // Contents survive reset, so this port has none.
  always_ff @(posedge clock) begin
    if (w_wr) begin
      for (int k = 0; k < APP_MASK_WIDTH; k++) begin
        if (!i_mask[k]) begin
          r_mem[w_idx][8*k +: 8] <= i_data[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state               <= S_INIT;
      r_cnt                 <= '0;
      r_idx                 <= '0;
      o_init_calib_complete <= 1'b0;
      o_data                <= '0;
      o_data_valid          <= 1'b0;
      o_busy                <= 1'b1;
    end else begin
      unique case (r_state)
        S_INIT: begin
          if (r_cnt == 32'(INIT_CYCLES - 1)) begin
            r_state               <= S_IDLE;
            r_cnt                 <= '0;
            o_init_calib_complete <= 1'b1;
            o_busy                <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_IDLE: begin
          if (i_wen) begin
            r_state <= S_WRITE;
            r_cnt   <= 32'(WRITE_BUSY);
            o_busy  <= 1'b1;
          end else if (i_ren) begin
            r_state <= S_RWAIT;
            r_idx   <= w_idx;
            r_cnt   <= 32'(READ_LATENCY - 1);
            o_busy  <= 1'b1;
          end
        end
        S_WRITE: begin
          if (r_cnt == 32'd1) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            o_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_RWAIT: begin
          if (r_cnt == 32'd0) begin
            r_state      <= S_RHOLD;
            o_data       <= r_mem[r_idx];
            o_data_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_RHOLD: begin
          if (!i_busy) begin
            r_state      <= S_IDLE;
            o_data_valid <= 1'b0;
            o_busy       <= 1'b0;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_bram_responder.sv
// Scoreboard bench for dram_bram_responder: directed cases, then random ops.
// The monitor pops expected read data whenever a beat retires.
module tb_dram_bram_responder;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam int RL = 4;

  logic          clock;
  logic          reset;
  logic          i_ren;
  logic          i_wen;
  logic [AW-2:0] i_addr;
  logic [DW-1:0] i_data;
  logic [MW-1:0] i_mask;
  logic          i_busy;
  logic          o_init_calib_complete;
  logic [DW-1:0] o_data;
  logic          o_data_valid;
  logic          o_busy;

  int errors;
  int checks;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [int];

  logic          prev_v;
  logic          prev_b;
  logic [DW-1:0] prev_d;

  dram_bram_responder dut (
    .clock                 (clock),
    .reset                 (reset),
    .i_ren                 (i_ren),
    .i_wen                 (i_wen),
    .i_addr                (i_addr),
    .i_data                (i_data),
    .i_mask                (i_mask),
    .i_busy                (i_busy),
    .o_init_calib_complete (o_init_calib_complete),
    .o_data                (o_data),
    .o_data_valid          (o_data_valid),
    .o_busy                (o_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic int widx(input logic [AW-2:0] a);
    return (int'(a) / 8) % 4096;
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy !== 1'b0 && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy required idle");
    end
  endtask

  task automatic init_count();
    int n = 0;
    i_ren  = 1'b1;
    i_addr = 27'($urandom);
    while (o_init_calib_complete !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    i_ren = 1'b0;
    check("init_cycles", DW'(n), DW'(64));
    check("init_busy", DW'(o_busy), DW'(0));
  endtask

  task automatic do_write(input logic [AW-2:0] a,
                          input logic [DW-1:0] d,
                          input logic [MW-1:0] m,
                          input logic both);
    logic [DW-1:0] w;
    wait_idle();
    i_wen  = 1'b1;
    i_ren  = both;
    i_addr = a;
    i_data = d;
    i_mask = m;
    step();
    w = model.exists(widx(a)) ? model[widx(a)] : '0;
    for (int k = 0; k < MW; k++)
      if (!m[k]) w[8*k +: 8] = d[8*k +: 8];
    model[widx(a)] = w;
    i_wen  = 1'b0;
    i_ren  = 1'($urandom_range(0, 1));
    i_addr = 27'($urandom);
    check("wr_busy_c1", DW'(o_busy), DW'(1));
    step();
    check("wr_busy_c2", DW'(o_busy), DW'(1));
    check("wr_no_valid", DW'(o_data_valid), DW'(0));
    step();
    i_ren = 1'b0;
    check("wr_busy_end", DW'(o_busy), DW'(0));
    check("wr_no_valid2", DW'(o_data_valid), DW'(0));
  endtask

  task automatic do_read(input logic [AW-2:0] a, input int hold);
    logic [DW-1:0] e;
    int n;
    wait_idle();
    i_busy = (hold > 0) ? 1'b1 : 1'($urandom_range(0, 1));
    i_ren  = 1'b1;
    i_addr = a;
    step();
    i_ren = 1'b0;
    e = model[widx(a)];
    exp_q.push_back(e);
    for (int k = 0; k < RL; k++) begin
      check("rd_latency_low", DW'(o_data_valid), DW'(0));
      step();
    end
    check("rd_latency_high", DW'(o_data_valid), DW'(1));
    if (hold > 0) begin
      for (int j = 1; j < hold; j++) begin
        step();
        check("rd_hold_valid", DW'(o_data_valid), DW'(1));
        check("rd_hold_data", o_data, e);
      end
      i_busy = 1'b0;
      step();
    end else begin
      n = 0;
      do begin
        i_busy = ($urandom_range(0, 2) == 0);
        step();
        n++;
      end while (i_busy && n < 100);
      i_busy = 1'b0;
      if (n >= 100) step();
    end
    check("rd_retired", DW'(o_data_valid), DW'(0));
    check("rd_data_kept", o_data, e);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      prev_v <= 1'b0;
      prev_b <= 1'b0;
    end else begin
      if (prev_v && prev_b) begin
        check("mon_stable_valid", DW'(o_data_valid), DW'(1));
        check("mon_stable_data", o_data, prev_d);
      end
      if (o_data_valid && !i_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: got %h required none", o_data);
        end else begin
          check("mon_data", o_data, exp_q.pop_front());
        end
      end
      prev_v <= o_data_valid;
      prev_b <= i_busy;
      prev_d <= o_data;
    end
  end

  initial begin
    logic [DW-1:0] d2;
    logic [AW-2:0] a;
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    i_ren  = 1'b0;
    i_wen  = 1'b0;
    i_addr = '0;
    i_data = '0;
    i_mask = '0;
    i_busy = 1'b0;
    d2 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    step();
    step();
    check("rst_calib", DW'(o_init_calib_complete), DW'(0));
    check("rst_valid", DW'(o_data_valid), DW'(0));
    check("rst_busy", DW'(o_busy), DW'(1));
    check("rst_data", o_data, '0);
    reset = 1'b0;
    init_count();

    do_write(27'h10, d2, 16'h0000, 1'b0);
    do_read(27'h10, 0);
    do_write(27'h10, {16{8'hFF}}, 16'hFFFE, 1'b0);
    do_read(27'h10, 0);
    check("model_mask", model[widx(27'h10)], d2);
    do_read(27'h10, 5);
    do_write(27'h20, {16{8'h5A}}, 16'h0000, 1'b1);
    do_read(27'h8020, 0);
    check("model_alias", model[widx(27'h8020)], {16{8'h5A}});

    wait_idle();
    i_ren  = 1'b1;
    i_addr = 27'h10;
    step();
    i_ren = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_valid", DW'(o_data_valid), DW'(0));
    check("mid_rst_calib", DW'(o_init_calib_complete), DW'(0));
    check("mid_rst_busy", DW'(o_busy), DW'(1));
    step();
    step();
    reset = 1'b0;
    init_count();
    do_read(27'h10, 0);

    for (int i = 0; i < 16; i++) begin
      a = 27'(($urandom & 32'h07FF8007) | (i << 3));
      do_write(a, rnd128(), 16'h0000, 1'b0);
    end
    for (int i = 0; i < 150; i++) begin
      a = 27'(($urandom & 32'h07FF8007) | ($urandom_range(0, 15) << 3));
      if ($urandom_range(0, 1) == 0)
        do_write(a, rnd128(), 16'($urandom), 1'($urandom_range(0, 1)));
      else
        do_read(a, ($urandom_range(0, 4) == 0) ? 3 : 0);
    end
    step();
    step();
    check("queue_empty", DW'(exp_q.size()), DW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
